// File: rtl/stopwatch_display_scan.sv
// Multiplexed 4-digit 7-segment driver for a BCD stopwatch (mm.ss).
// Scans one digit per REFRESH_DIV cycles, supports lap hold and
// leading-zero blanking. Outputs are registered.
module stopwatch_display_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       lap,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic [1:0] digit_sel
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] presc;
  logic          tick;
  logic [1:0]    idx;
  logic [15:0]   cap;

  logic [3:0]    cur;
  logic          blank;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;
  logic          dp_nxt;

  assign tick      = (presc == LAST);
  assign digit_sel = idx;

  // Prescaler: counts 0..REFRESH_DIV-1, ticks on the last count
  always_ff @(posedge clk) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Scan index advances one slot per tick
  always_ff @(posedge clk) begin
    if (reset)     idx <= '0;
    else if (tick) idx <= idx + 2'd1;
  end

  // Capture register: live while lap is low, frozen while lap is high
  always_ff @(posedge clk) begin
    if (reset)     cap <= '0;
    else if (!lap) cap <= {d3, d2, d1, d0};
  end

  // Select the scanned digit, apply blanking and decode
  always_comb begin
    cur     = '0;
    blank   = 1'b0;
    seg_nxt = '0;
    an_nxt  = '1;
    dp_nxt  = 1'b0;

    case (idx)
      2'd0: cur = cap[3:0];
      2'd1: cur = cap[7:4];
      2'd2: cur = cap[11:8];
      default: cur = cap[15:12];
    endcase

    if (blank_lz) begin
      case (idx)
        2'd3: blank = (cap[15:12] == 4'd0);
        2'd2: blank = (cap[15:8] == 8'd0);
        2'd1: blank = (cap[15:4] == 12'd0);
        default: blank = 1'b0;
      endcase
    end

    case (cur)
      4'd0: seg_nxt = 7'b0111111;
      4'd1: seg_nxt = 7'b0000110;
      4'd2: seg_nxt = 7'b1011011;
      4'd3: seg_nxt = 7'b1001111;
      4'd4: seg_nxt = 7'b1100110;
      4'd5: seg_nxt = 7'b1101101;
      4'd6: seg_nxt = 7'b1111101;
      4'd7: seg_nxt = 7'b0000111;
      4'd8: seg_nxt = 7'b1111111;
      4'd9: seg_nxt = 7'b1101111;
      default: seg_nxt = 7'b1000000;
    endcase

    if (blank) begin
      seg_nxt = '0;
    end else begin
      an_nxt = ~(4'b0001 << idx);
      dp_nxt = (idx == 2'd2);
    end
  end

  // Output register, driven from pre-edge capture and index
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= '0;
      an  <= '1;
      dp  <= 1'b0;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Directed bench for stopwatch_display_scan with REFRESH_DIV=4.
module tb_stopwatch_display_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic       lap = 1'b0;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [1:0] digit_sel;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned k = 0;

  stopwatch_display_scan #(.REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .lap(lap), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        blz;
    int unsigned slot;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_dp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
    end
  endtask

  // Advance n edges; sample 1ns after each rising edge
  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic set_d(input logic [15:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  // Apply reset for one edge, then release with k counting edges since release
  task automatic do_reset(input logic [15:0] v, input logic blz);
    reset = 1'b1;
    set_d(v);
    blank_lz = blz;
    lap = 1'b0;
    step(1);
    reset = 1'b0;
    k = 0;
  endtask

  task automatic check_out(input string name, input logic [6:0] s, input logic [3:0] a, input logic p);
    check({name, ".seg"}, 16'(seg), 16'(s));
    check({name, ".an"},  16'(an),  16'(a));
    check({name, ".dp"},  16'(dp),  16'(p));
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 1'b0, 0, 7'b1100110, 4'b1110, 1'b0};
    vecs[1]  = '{16'h1234, 1'b0, 1, 7'b1001111, 4'b1101, 1'b0};
    vecs[2]  = '{16'h1234, 1'b0, 2, 7'b1011011, 4'b1011, 1'b1};
    vecs[3]  = '{16'h1234, 1'b0, 3, 7'b0000110, 4'b0111, 1'b0};
    vecs[4]  = '{16'h0007, 1'b1, 0, 7'b0000111, 4'b1110, 1'b0};
    vecs[5]  = '{16'h0007, 1'b1, 1, 7'b0000000, 4'b1111, 1'b0};
    vecs[6]  = '{16'h0007, 1'b1, 2, 7'b0000000, 4'b1111, 1'b0};
    vecs[7]  = '{16'h0007, 1'b1, 3, 7'b0000000, 4'b1111, 1'b0};
    vecs[8]  = '{16'h0500, 1'b1, 0, 7'b0111111, 4'b1110, 1'b0};
    vecs[9]  = '{16'h0500, 1'b1, 1, 7'b0111111, 4'b1101, 1'b0};
    vecs[10] = '{16'h0500, 1'b1, 2, 7'b1101101, 4'b1011, 1'b1};
    vecs[11] = '{16'h0500, 1'b1, 3, 7'b0000000, 4'b1111, 1'b0};
    vecs[12] = '{16'h000C, 1'b0, 0, 7'b1000000, 4'b1110, 1'b0};
    vecs[13] = '{16'h0009, 1'b0, 0, 7'b1101111, 4'b1110, 1'b0};
    vecs[14] = '{16'h0500, 1'b0, 3, 7'b0111111, 4'b0111, 1'b0};
    vecs[15] = '{16'h00A0, 1'b1, 1, 7'b1000000, 4'b1101, 1'b0};

    // Reset values after several reset edges
    set_d(16'h1234);
    step(3);
    check("rst.digit_sel", 16'(digit_sel), 16'd0);
    check_out("rst", 7'b0000000, 4'b1111, 1'b0);

    // First edge after release shows digit 0 of the zero capture
    do_reset(16'h1234, 1'b0);
    step(1);
    check_out("first", 7'b0111111, 4'b1110, 1'b0);

    // Table: slot s is displayed after edge 4*s+2 following release
    for (int i = 0; i < 16; i++) begin
      do_reset(vecs[i].d, vecs[i].blz);
      step(4 * vecs[i].slot + 2);
      check($sformatf("v%0d.digit_sel", i), 16'(digit_sel), 16'(vecs[i].slot));
      check_out($sformatf("v%0d", i), vecs[i].e_seg, vecs[i].e_an, vecs[i].e_dp);
    end

    // Lap hold: freeze 12.34, change inputs, release to 56.78
    do_reset(16'h1234, 1'b0);
    step(2);
    lap = 1'b1;
    set_d(16'h5678);
    step(4);   // k=6, slot 1
    check_out("lap.s1", 7'b1001111, 4'b1101, 1'b0);
    step(4);   // k=10, slot 2
    check_out("lap.s2", 7'b1011011, 4'b1011, 1'b1);
    step(4);   // k=14, slot 3
    check_out("lap.s3", 7'b0000110, 4'b0111, 1'b0);
    step(4);   // k=18, slot 0
    check_out("lap.s0", 7'b1100110, 4'b1110, 1'b0);
    lap = 1'b0;
    step(2);   // k=20, slot 0 from new capture
    check_out("unlap.s0", 7'b1111111, 4'b1110, 1'b0);
    step(2);   // k=22, slot 1
    check_out("unlap.s1", 7'b0000111, 4'b1101, 1'b0);

    // Reset mid-scan at digit 2 with lap held
    do_reset(16'h1234, 1'b0);
    step(10);
    check("mid.digit_sel", 16'(digit_sel), 16'd2);
    lap = 1'b1;
    set_d(16'h5678);
    step(1);
    reset = 1'b1;
    step(1);
    check("mrst.digit_sel", 16'(digit_sel), 16'd0);
    check_out("mrst", 7'b0000000, 4'b1111, 1'b0);
    reset = 1'b0;
    k = 0;
    step(2);
    check_out("mrel.s0", 7'b0111111, 4'b1110, 1'b0);
    step(1);
    check("mrel.k3.digit_sel", 16'(digit_sel), 16'd0);
    step(1);
    check("mrel.k4.digit_sel", 16'(digit_sel), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/stopwatch_display_scan.md
STOPWATCH_DISPLAY_SCAN -- requirements
Module: stopwatch_display_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles each digit is driven per scan slot (legal range 1..2^20).
REQ-002 Port clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Ports d0, d1, d2, d3  input  4 each  BCD digits from the cascaded 0-9 counters; d0 is least significant.
REQ-005 Port lap  input  1  when high, freezes the displayed value (lap hold).
REQ-006 Port blank_lz  input  1  when high, enables leading-zero blanking.
REQ-007 Port seg  output  7  segment drive, active-high; seg[0]=a ... seg[6]=g.
REQ-008 Port dp  output  1  decimal point, active-high.
REQ-009 Port an  output  4  digit enables, active-low, one-hot; an[i] drives digit i.
REQ-010 Port digit_sel  output  2  index of the digit slot currently scanned.

Function
REQ-011 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; a tick SHALL occur in the cycle the count equals REFRESH_DIV-1.
REQ-012 With REFRESH_DIV=1 a tick SHALL occur every cycle.
REQ-013 Scan index SHALL advance 0->1->2->3->0 on each tick, otherwise hold; digit_sel SHALL equal the index.
REQ-014 Capture register SHALL load {d3,d2,d1,d0} on every edge where lap=0 and SHALL hold its value while lap=1.
REQ-015 seg, dp and an SHALL be registered from the capture register and the scan index as they stand before the edge; an input change is therefore visible on seg two edges after it is sampled, provided its digit is selected.
REQ-016 Decode SHALL be: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111 (seg[6:0]).
REQ-017 Captured values 10-15 SHALL be displayed as a dash, seg=1000000.
REQ-018 With blank_lz=1: digit 3 SHALL be blank if c3=0; digit 2 SHALL be blank if c3=c2=0; digit 1 SHALL be blank if c3=c2=c1=0; digit 0 SHALL never be blank.
REQ-019 A blank slot SHALL drive an=1111, seg=0000000, dp=0; the slot still occupies its full REFRESH_DIV cycles.
REQ-020 A non-blank slot SHALL drive an with only bit [index] low.
REQ-021 dp SHALL be 1 exactly when index=2 and the slot is not blank (mm.ss separator).
REQ-022 With blank_lz=0, no digit SHALL be blanked.
REQ-023 The lap level SHALL act every cycle; releasing lap SHALL resume live capture on the next edge, with no effect on prescaler or index.

Reset
REQ-024 While reset=1: prescaler=0, index=0, capture=0, seg=0000000, dp=0, an=1111, digit_sel=0.
REQ-025 reset SHALL override lap and any pending tick.
REQ-026 Reset asserted mid-scan SHALL restart the scan at digit 0 with a full REFRESH_DIV slot after deassertion.
REQ-027 On the first edge after reset deasserts, the block SHALL capture the inputs if lap=0 and SHALL register digit 0's outputs from the zero capture (seg=0111111, an=1110).

Verification
REQ-028 REFRESH_DIV=4; d3..d0=1,2,3,4; lap=0; blank_lz=0; release reset -> digit_sel steps 0,1,2,3 every 4 cycles; seg=1100110/an=1110, 1001111/1101, 1011011/1011 with dp=1, 0000110/0111.
REQ-029 blank_lz=1; d3..d0=0,0,0,7 -> slots 3,2,1 give an=1111, seg=0; slot 0 gives an=1110, seg=0000111; dp stays 0.
REQ-030 blank_lz=1; d3..d0=0,5,0,0 -> slot 3 blank; slot 2 shows 5 with dp=1; slots 1 and 0 show 0 (0111111).
REQ-031 d0=4'hC -> slot 0 seg=1000000; d0=9 -> slot 0 seg=1101111.
REQ-032 Show 12.34; raise lap; change inputs to 5,6,7,8 -> display stays 12.34; drop lap -> 56.78 appears within two edges of each slot.
REQ-033 Assert reset one cycle while digit_sel=2 with lap=1 -> outputs hold reset values during reset; after release scan restarts at digit 0 with a full 4-cycle slot and the lap-held value is lost.
